uart_rx_ctrl: RTL and testbench

Receive-side frame controller for the UART RX path. It detects the start bit and runs the per-bit edge counter and bit counter that drive the `data_sampling` block. It consumes the majority-voted `sampled_bit`, deserialises 8 data bits LSB-first, checks the optional parity bit and the stop bit, and presents the received byte with a one-cycle valid strobe. It sits between the synchronised serial input and the RX output register interface.

---
 rtl/uart_rx_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: start detection, bit/edge counting, LSB-first deserialise, parity and stop checks.
// Latency: data_valid rises 1+N*prescale cycles after the start bit is first seen (N = start+data+parity+stop).
// Backpressure: none; data_valid is a one-cycle strobe and P_DATA holds until the next good frame.
module uart_rx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic [5:0]        prescale,
    input  logic              sampled_bit,
    output logic              data_samp_en,
    output logic [5:0]        edge_cnt,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              strt_glitch
);

    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [5:0]        ps_last;
    logic [5:0]        ps_clamped;
    logic              par_en_q;
    logic              par_typ_q;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic              parity_q;
    logic              bit_end;

    always_comb begin
        ps_clamped = (prescale < 6'd8) ? 6'd8 : prescale;
        bit_end    = (edge_cnt == ps_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            strt_glitch  <= 1'b0;
            data_samp_en <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            ps_last      <= 6'd7;
        end else begin
            data_valid  <= 1'b0;
            strt_glitch <= 1'b0;
            if (state == IDLE) begin
                edge_cnt     <= '0;
                data_samp_en <= 1'b0;
                if (!RX_IN) begin
                    // Frame configuration is frozen here; mid-frame input changes are ignored.
                    state        <= START;
                    data_samp_en <= 1'b1;
                    par_err      <= 1'b0;
                    stp_err      <= 1'b0;
                    par_en_q     <= PAR_EN;
                    par_typ_q    <= PAR_TYP;
                    ps_last      <= ps_clamped - 6'd1;
                end
            end else begin
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
                if (bit_end) begin
                    case (state)
                        START: begin
                            if (sampled_bit) begin
                                strt_glitch  <= 1'b1;
                                state        <= IDLE;
                                data_samp_en <= 1'b0;
                            end else begin
                                state    <= DATA;
                                bit_cnt  <= '0;
                                parity_q <= 1'b0;
                            end
                        end
                        DATA: begin
                            shift_q  <= {sampled_bit, shift_q[DATA_W-1:1]};
                            parity_q <= parity_q ^ sampled_bit;
                            bit_cnt  <= bit_cnt + BW'(1);
                            if (bit_cnt == BW'(DATA_W - 1))
                                state <= par_en_q ? PARITY : STOP;
                        end
                        PARITY: begin
                            if (sampled_bit != (parity_q ^ par_typ_q))
                                par_err <= 1'b1;
                            state <= STOP;
                        end
                        STOP: begin
                            // par_err was cleared at start detection, so it reflects this frame only.
                            if (!sampled_bit)
                                stp_err <= 1'b1;
                            else if (!par_err) begin
                                P_DATA     <= shift_q;
                                data_valid <= 1'b1;
                            end
                            state        <= IDLE;
                            data_samp_en <= 1'b0;
                        end
                        default: begin
                            state        <= IDLE;
                            data_samp_en <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame-level reference model feeds a scoreboard; a majority-vote sampler stands in for data_sampling.
module tb_uart_rx_ctrl;

    localparam int DATA_W  = 8;
    localparam int K_VALID = 0;
    localparam int K_GLTCH = 1;
    localparam int K_PERR  = 2;
    localparam int K_SERR  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              RX_IN;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic [5:0]        prescale;
    logic              sampled_bit;
    logic              data_samp_en;
    logic [5:0]        edge_cnt;
    logic [DATA_W-1:0] P_DATA;
    logic              data_valid;
    logic              par_err;
    logic              stp_err;
    logic              strt_glitch;

    uart_rx_ctrl #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .prescale     (prescale),
        .sampled_bit  (sampled_bit),
        .data_samp_en (data_samp_en),
        .edge_cnt     (edge_cnt),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .strt_glitch  (strt_glitch)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the current clock period between posedges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        int         at;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_good = 8'h00;
    int         eff_p = 8;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in for data_sampling: three captures around mid-bit, vote published one cycle after half.
    logic s0, s1, s2;
    always @(posedge clk) begin
        if (rst) begin
            sampled_bit <= 1'b1;
        end else if (data_samp_en) begin
            if (int'(edge_cnt) == eff_p / 2 - 2) s0 <= RX_IN;
            if (int'(edge_cnt) == eff_p / 2 - 1) s1 <= RX_IN;
            if (int'(edge_cnt) == eff_p / 2)     s2 <= RX_IN;
            if (int'(edge_cnt) == eff_p / 2 + 1) sampled_bit <= (s0 & s1) | (s0 & s2) | (s1 & s2);
        end
    end

    task automatic pop_check(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_cycle", 32'(cyc), 32'(e.at));
            check("p_data", 32'(P_DATA), 32'(e.data));
            if (kind == K_VALID) begin
                check("valid_par_err", 32'(par_err), 32'(0));
                check("valid_stp_err", 32'(stp_err), 32'(0));
            end
        end
    endtask

    logic prev_pe = 1'b0;
    logic prev_se = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (data_valid)            pop_check(K_VALID);
            if (strt_glitch)           pop_check(K_GLTCH);
            if (par_err && !prev_pe)   pop_check(K_PERR);
            if (stp_err && !prev_se)   pop_check(K_SERR);
        end
        prev_pe = par_err;
        prev_se = stp_err;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called in a period where the DUT is idle; the start bit is low from this period on.
    task automatic send_frame(input int p_raw, input bit pen, input bit ptyp, input logic [7:0] data,
                              input bit par_bad, input bit stop_bad, input int gap);
        int   p;
        int   n;
        int   t;
        bit   perr;
        logic bits[$];
        p        = (p_raw < 8) ? 8 : p_raw;
        n        = 2 + DATA_W + int'(pen);
        perr     = pen && par_bad;
        t        = cyc;
        prescale = 6'(p_raw);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        eff_p    = p;
        if (perr)
            exp_q.push_back('{K_PERR, t + 1 + (DATA_W + 2) * p, last_good});
        if (stop_bad)
            exp_q.push_back('{K_SERR, t + 1 + n * p, last_good});
        if (!perr && !stop_bad) begin
            exp_q.push_back('{K_VALID, t + 1 + n * p, data});
            last_good = data;
        end
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(data[i]);
        if (pen) bits.push_back((^data) ^ ptyp ^ par_bad);
        bits.push_back(!stop_bad);
        RX_IN = 1'b0;
        wait_cycles(1);
        check("start_clears_par_err", 32'(par_err), 32'(0));
        check("start_clears_stp_err", 32'(stp_err), 32'(0));
        check("start_samp_en", 32'(data_samp_en), 32'(1));
        // Config inputs wander mid-frame; the DUT must keep what it latched.
        prescale = 6'($urandom_range(0, 63));
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        wait_cycles(p - 1);
        for (int i = 1; i < bits.size(); i++) begin
            RX_IN = bits[i];
            wait_cycles(p);
        end
        RX_IN = 1'b1;
        wait_cycles(gap);
    endtask

    task automatic send_glitch(input int p_raw, input int low_len, input int gap);
        int p;
        int t;
        p        = (p_raw < 8) ? 8 : p_raw;
        t        = cyc;
        prescale = 6'(p_raw);
        eff_p    = p;
        exp_q.push_back('{K_GLTCH, t + 1 + p, last_good});
        RX_IN = 1'b0;
        wait_cycles(low_len);
        RX_IN = 1'b1;
        wait_cycles(p - low_len + gap);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_samp_en"}, 32'(data_samp_en), 32'(0));
        check({tag, "_edge_cnt"}, 32'(edge_cnt), 32'(0));
        check({tag, "_p_data"}, 32'(P_DATA), 32'(0));
        check({tag, "_data_valid"}, 32'(data_valid), 32'(0));
        check({tag, "_par_err"}, 32'(par_err), 32'(0));
        check({tag, "_stp_err"}, 32'(stp_err), 32'(0));
        check({tag, "_strt_glitch"}, 32'(strt_glitch), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pr;
        bit pen;
        rst      = 1'b1;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        prescale = 6'd8;
        wait_cycles(3);
        check_all_zero("reset");
        rst = 1'b0;
        wait_cycles(2);

        send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 3);
        send_frame(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 3);
        send_frame(8, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 3);
        send_frame(8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1);
        send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 3);
        send_glitch(8, 3, 2);
        send_frame(3, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 2);
        // Back-to-back: each new start is seen in the cycle data_valid is high.
        send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1);
        send_frame(8, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0, 1);

        prescale = 6'd8;
        PAR_EN   = 1'b0;
        eff_p    = 8;
        RX_IN    = 1'b0;
        wait_cycles(30);
        rst   = 1'b1;
        RX_IN = 1'b1;
        wait_cycles(1);
        check_all_zero("midframe_rst");
        rst       = 1'b0;
        last_good = 8'h00;
        wait_cycles(3);

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                send_glitch(8 << $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(1, 4));
            end else begin
                case ($urandom_range(0, 3))
                    0:       pr = $urandom_range(0, 7);
                    1:       pr = 8;
                    2:       pr = 16;
                    default: pr = 32;
                endcase
                pen = 1'($urandom);
                send_frame(pr, pen, 1'($urandom), 8'($urandom),
                           pen && ($urandom_range(0, 4) == 0), $urandom_range(0, 4) == 0,
                           $urandom_range(1, 4));
            end
        end

        wait_cycles(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
